bell_queue: RTL and testbench
=============================

BELL_QUEUE -- requirements
Module: bell_queue

Interface
REQ-001 Parameter MAX_PENDING, default 15: saturation limit of queued bell requests; legal range 1..15.
REQ-002 Parameter TRIGGER_CYCLES, default 4: width of each trigger pulse in clocks; legal range 1..255.
REQ-003 Parameter GAP_CYCLES, default 2500000: enforced silence between bells, 50 ms at 50 MHz; legal range 1..4194303, counter is 22 bits.
REQ-004 Parameter ACK_TIMEOUT, default 16: clocks to wait for the bell to go busy after a trigger; legal range 1..255.
REQ-005 clk_50_i  in  1  system clock; all logic runs on its rising edge.
REQ-006 reset_n_i  in  1  reset; asynchronous, active-low.
REQ-007 char_valid_i  in  1  one-cycle strobe qualifying char_i.
REQ-008 char_i  in  8  character from the display/terminal stream.
REQ-009 enable_i  in  1  bell feature enable.
REQ-010 clear_i  in  1  synchronous clear of overflow_o.
REQ-011 bell_done_i  in  1  idle status from the downstream bell tone generator: 1 = idle, 0 = playing.
REQ-012 bell_trigger_o  out  1  trigger to the downstream bell; the bell starts on its rising edge.
REQ-013 pending_o  out  4  number of queued, unissued bell requests.
REQ-014 busy_o  out  1  high whenever the FSM is not in IDLE.
REQ-015 overflow_o  out  1  sticky flag: a BEL was dropped because the queue was saturated.

Function
REQ-016 The block SHALL detect a BEL when char_valid_i=1, char_i[6:0]=7'h07, and enable_i=1; char_i[7] is ignored because Apple II high-bit characters are accepted.
REQ-017 On a BEL, the block SHALL increment pending by 1 when pending<MAX_PENDING; otherwise pending stays unchanged and overflow_o is set to 1.
REQ-018 When a BEL and a dequeue occur in the same cycle, the block SHALL leave pending unchanged and SHALL NOT set overflow_o, even at MAX_PENDING.
REQ-019 While enable_i=0, the block SHALL clear pending to 0 and ignore characters; a bell already in progress still completes through the FSM.
REQ-020 clear_i=1 SHALL clear overflow_o on the next edge; when a saturating BEL occurs in the same cycle, the set wins.
REQ-021 The FSM SHALL have five states: IDLE, TRIG, WAIT_BUSY, WAIT_DONE, GAP.
REQ-022 IDLE -> TRIG when pending>0 and bell_done_i=1; pending is decremented by 1 on that same edge (dequeue).
REQ-023 TRIG SHALL drive bell_trigger_o=1 for exactly TRIGGER_CYCLES clocks, then move to WAIT_BUSY.
REQ-024 bell_trigger_o SHALL be 0 in every state other than TRIG, and SHALL be registered (glitch-free).
REQ-025 WAIT_BUSY -> WAIT_DONE when bell_done_i=0; otherwise -> GAP after ACK_TIMEOUT clocks in WAIT_BUSY. A timed-out request is consumed, not requeued.
REQ-026 WAIT_DONE -> GAP when bell_done_i=1; there is no timeout in this state.
REQ-027 GAP SHALL count GAP_CYCLES clocks, then move to IDLE; a new trigger therefore cannot start until GAP_CYCLES after the bell finishes.
REQ-028 Latency: with pending>0 and the FSM in IDLE, bell_trigger_o rises 1 clock after the dequeue edge, i.e. on the first TRIG cycle.
REQ-029 A BEL arriving in IDLE with pending=0 SHALL produce trigger rise 2 clocks after the strobe edge: pending increments, then dequeue, then TRIG.
REQ-030 busy_o SHALL be registered and equal 1 in TRIG, WAIT_BUSY, WAIT_DONE, and GAP.
REQ-031 pending_o SHALL reflect the registered pending count, which is never greater than MAX_PENDING.

Reset
REQ-032 While reset_n_i=0 the block SHALL asynchronously force: FSM=IDLE, pending_o=0, bell_trigger_o=0, busy_o=0, overflow_o=0, and all counters to 0.
REQ-033 Reset asserted mid-TRIG SHALL drop bell_trigger_o to 0 immediately, without waiting for a clock edge.
REQ-034 Reset release SHALL take effect on the first clock edge after reset_n_i=1; no BEL is generated by reset itself.

Verification (TRIGGER_CYCLES=4, GAP_CYCLES=10, ACK_TIMEOUT=16, bell model: done low 3 clocks after trigger rise, high 20 clocks later)
REQ-035 Single BEL char_i=8'h87 in IDLE -> trigger high 4 clocks starting 2 clocks after the strobe; busy_o stays high until 10 clocks after done returns high; pending_o returns to 0.
REQ-036 Three back-to-back BELs (8'h07) -> pending_o peaks at 2; exactly three trigger pulses; each pulse starts no earlier than 10 clocks after the previous done rise.
REQ-037 Twenty BELs while bell_done_i held 0 -> pending_o=15 and overflow_o=1; clear_i pulse -> overflow_o=0 and pending_o=15 unchanged.
REQ-038 bell_done_i stuck at 1 -> after one trigger pulse, the FSM enters GAP after 16 WAIT_BUSY clocks; pending decreases by 1 per attempt.
REQ-039 enable_i=0 with pending=5 mid-WAIT_DONE -> pending_o=0 on the next edge; the current bell completes; no further triggers occur.
REQ-040 Async reset asserted in TRIG between clock edges -> bell_trigger_o=0 before the next edge; all outputs at reset values.

Source files
------------

// File: rtl/bell_queue_if.sv
// Bell queue signal bundle: character stream in, bell handshake and status out.
// Latency: none, wires only.
// Backpressure: none; the character strobe is never stalled, and excess BELs set a sticky overflow flag.
interface bell_queue_if;
  // Character stream and controls
  logic       char_valid_i;
  logic [7:0] char_i;
  logic       enable_i;
  logic       clear_i;
  // Downstream bell tone generator status (1 = idle)
  logic       bell_done_i;
  // Outputs of the queue
  logic       bell_trigger_o;
  logic [3:0] pending_o;
  logic       busy_o;
  logic       overflow_o;

  // Seen from the bell queue itself
  modport slave (
    input  char_valid_i,
    input  char_i,
    input  enable_i,
    input  clear_i,
    input  bell_done_i,
    output bell_trigger_o,
    output pending_o,
    output busy_o,
    output overflow_o
  );

  // Seen from whatever drives the character stream and bell status
  modport master (
    output char_valid_i,
    output char_i,
    output enable_i,
    output clear_i,
    output bell_done_i,
    input  bell_trigger_o,
    input  pending_o,
    input  busy_o,
    input  overflow_o
  );
endinterface

// File: rtl/bell_queue.sv
// Counts BEL characters and replays each one as a fixed-width trigger pulse, enforcing a silent gap between bells.
// Latency: the trigger rises on the first TRIG cycle, one clock after the dequeue edge, and two clocks after a BEL into an empty idle queue.
// Backpressure: none upstream; BELs beyond MAX_PENDING are dropped and set overflow_o until it is cleared.
module bell_queue #(
  parameter int MAX_PENDING    = 15,
  parameter int TRIGGER_CYCLES = 4,
  parameter int GAP_CYCLES     = 2500000,
  parameter int ACK_TIMEOUT    = 16
) (
  input logic          clk_50_i,
  input logic          reset_n_i,
  bell_queue_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  // Terminal counts. One shared 22-bit counter serves the TRIG, WAIT_BUSY and GAP
  // phases because they never overlap; it is zeroed on every state change.
  localparam logic [21:0] TRIG_LAST = 22'(TRIGGER_CYCLES - 1);
  localparam logic [21:0] ACK_LAST  = 22'(ACK_TIMEOUT - 1);
  localparam logic [21:0] GAP_LAST  = 22'(GAP_CYCLES - 1);
  localparam logic [3:0]  MAX_P     = 4'(MAX_PENDING);

  state_t      state_q, state_d;
  logic [21:0] cnt_q, cnt_d;
  logic [3:0]  pending_q, pending_d;
  logic        overflow_q, overflow_d;
  logic        trigger_q, trigger_d;
  logic        busy_q, busy_d;

  logic        bel_hit;
  logic        deq;
  logic        saturated;

  // Bit 7 of the character is deliberately ignored so Apple II high-bit BELs count.
  logic        unused_char_bit7;
  assign unused_char_bit7 = bus.char_i[7];

  // BEL detection and dequeue request; both are suppressed while the feature is disabled.
  always_comb begin
    bel_hit   = bus.char_valid_i && (bus.char_i[6:0] == 7'h07) && bus.enable_i;
    deq       = (state_q == IDLE) && (pending_q != 4'd0) && bus.bell_done_i && bus.enable_i;
    saturated = bel_hit && !deq && (pending_q == MAX_P);
  end

  // Pending count and sticky overflow; a BEL that coincides with a dequeue is a net no-op.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (!bus.enable_i) begin
      pending_d = 4'd0;
    end else if (bel_hit && !deq) begin
      if (!saturated) begin
        pending_d = pending_q + 4'd1;
      end
    end else if (deq && !bel_hit) begin
      pending_d = pending_q - 4'd1;
    end
    // A saturating BEL wins over a simultaneous clear.
    if (saturated) begin
      overflow_d = 1'b1;
    end else if (bus.clear_i) begin
      overflow_d = 1'b0;
    end
  end

  // Bell sequencer: trigger, wait for the bell to go busy, wait for it to finish, then hold off.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (deq) begin
          state_d = TRIG;
          cnt_d   = 22'd0;
        end
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_BUSY;
          cnt_d   = 22'd0;
        end else begin
          cnt_d = cnt_q + 22'd1;
        end
      end
      WAIT_BUSY: begin
        // A bell that never answers is given up on; its request is not requeued.
        if (!bus.bell_done_i) begin
          state_d = WAIT_DONE;
          cnt_d   = 22'd0;
        end else if (cnt_q == ACK_LAST) begin
          state_d = GAP;
          cnt_d   = 22'd0;
        end else begin
          cnt_d = cnt_q + 22'd1;
        end
      end
      WAIT_DONE: begin
        if (bus.bell_done_i) begin
          state_d = GAP;
          cnt_d   = 22'd0;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = 22'd0;
        end else begin
          cnt_d = cnt_q + 22'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 22'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    trigger_d = (state_d == TRIG);
    busy_d    = (state_d != IDLE);
  end

  // State registers; reset forces everything idle immediately, including a trigger mid-pulse.
  always_ff @(posedge clk_50_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= 22'd0;
      pending_q  <= 4'd0;
      overflow_q <= 1'b0;
      trigger_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      trigger_q  <= trigger_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.bell_trigger_o = trigger_q;
  assign bus.pending_o      = pending_q;
  assign bus.busy_o         = busy_q;
  assign bus.overflow_o     = overflow_q;

endmodule

// File: tb/tb_bell_queue.sv
// Bench for bell_queue: directed scenarios plus random character traffic against a timestamp-based reference model.
// Latency: expected outputs are queued one edge ahead and compared one time unit after each rising edge.
// Backpressure: none; the bell tone generator is modelled in the bench from the reference model's own trigger.
module tb_bell_queue;
  localparam int MAXP  = 15;
  localparam int TRIGC = 4;
  localparam int GAPC  = 10;
  localparam int ACKT  = 16;

  localparam int P_IDLE = 0;
  localparam int P_TRIG = 1;
  localparam int P_WB   = 2;
  localparam int P_WD   = 3;
  localparam int P_GAP  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bell_queue_if bif ();

  bell_queue #(
    .MAX_PENDING   (MAXP),
    .TRIGGER_CYCLES(TRIGC),
    .GAP_CYCLES    (GAPC),
    .ACK_TIMEOUT   (ACKT)
  ) u_dut (
    .clk_50_i (clk),
    .reset_n_i(rst_n),
    .bus      (bif.slave)
  );

  typedef struct packed {
    logic       trig;
    logic       busy;
    logic       ovf;
    logic [3:0] pend;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_x;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;
  int   dut_pulses = 0;
  int   dut_peak = 0;
  logic mon_prev_trig = 1'b0;

  // Reference model: phase plus the edge number at which it was entered
  int m_phase, m_since, m_pending, m_edge, m_rise;
  bit m_ovf;
  int bell_mode;   // 0 = realistic bell, 1 = done stuck high, 2 = done stuck low
  bit drv_en, drv_clr;

  function automatic void model_reset();
    m_phase   = P_IDLE;
    m_since   = m_edge;
    m_pending = 0;
    m_ovf     = 1'b0;
    m_rise    = -1000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired waiting for model phase (t=%0t)", name, $time);
  endtask

  // One clock: drive inputs at the falling edge, advance the model by one edge, queue expectation.
  task automatic cycle(input bit cv, input logic [7:0] ch);
    bit   done, bel, deq, sat;
    int   e, el;
    exp_t x;
    @(negedge clk);
    e = m_edge + 1;
    case (bell_mode)
      1:       done = 1'b1;
      2:       done = 1'b0;
      default: done = !(((e - m_rise) >= 3) && ((e - m_rise) < 23));
    endcase
    bif.char_valid_i = cv;
    bif.char_i       = ch;
    bif.enable_i     = drv_en;
    bif.clear_i      = drv_clr;
    bif.bell_done_i  = done;

    bel = cv && (ch[6:0] == 7'h07) && drv_en;
    deq = (m_phase == P_IDLE) && (m_pending > 0) && done && drv_en;
    sat = bel && !deq && (m_pending == MAXP);
    if (!drv_en) m_pending = 0;
    else m_pending = m_pending + ((bel && !sat) ? 1 : 0) - (deq ? 1 : 0);
    if (sat) m_ovf = 1'b1;
    else if (drv_clr) m_ovf = 1'b0;

    el = e - m_since;
    case (m_phase)
      P_IDLE: if (deq) begin m_phase = P_TRIG; m_since = e; m_rise = e; end
      P_TRIG: if (el == TRIGC) begin m_phase = P_WB; m_since = e; end
      P_WB: begin
        if (!done) begin m_phase = P_WD; m_since = e; end
        else if (el == ACKT) begin m_phase = P_GAP; m_since = e; end
      end
      P_WD:  if (done) begin m_phase = P_GAP; m_since = e; end
      default: if (el == GAPC) begin m_phase = P_IDLE; m_since = e; end
    endcase
    m_edge = e;

    x.trig = (m_phase == P_TRIG);
    x.busy = (m_phase != P_IDLE);
    x.ovf  = m_ovf;
    x.pend = 4'(m_pending);
    exp_q.push_back(x);
  endtask

  // Monitor: pop one expectation per rising edge and compare all outputs.
  always @(posedge clk) begin
    #1;
    if (chk_en && exp_q.size() > 0) begin
      mon_x = exp_q.pop_front();
      check("trigger", bif.bell_trigger_o, mon_x.trig);
      check("busy",    bif.busy_o,         mon_x.busy);
      check("overflow", bif.overflow_o,    mon_x.ovf);
      check("pending", bif.pending_o,      mon_x.pend);
      if (bif.bell_trigger_o === 1'b1 && mon_prev_trig !== 1'b1) dut_pulses++;
      mon_prev_trig = bif.bell_trigger_o;
      if (int'(bif.pending_o) > dut_peak) dut_peak = int'(bif.pending_o);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bif.char_valid_i = 1'b0;
    bif.char_i       = 8'h00;
    bif.enable_i     = 1'b0;
    bif.clear_i      = 1'b0;
    bif.bell_done_i  = 1'b1;
    drv_en = 1'b1; drv_clr = 1'b0; bell_mode = 0; m_edge = 0;
    model_reset();

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_trigger", bif.bell_trigger_o, 0);
    check("rst_busy",    bif.busy_o, 0);
    check("rst_pending", bif.pending_o, 0);
    check("rst_overflow", bif.overflow_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;

    // Single high-bit BEL: pending first, then trigger on the following edge
    dut_pulses = 0;
    cycle(1'b1, 8'h87);
    cycle(1'b0, 8'h00);
    check("lat_pending1", bif.pending_o, 1);
    check("lat_trig_low", bif.bell_trigger_o, 0);
    cycle(1'b0, 8'h00);
    check("lat_trig_high", bif.bell_trigger_o, 1);
    repeat (45) cycle(1'b0, 8'h00);
    check("single_pulses", dut_pulses, 1);
    check("single_pending", bif.pending_o, 0);
    check("single_busy", bif.busy_o, 0);

    // Three back-to-back BELs
    dut_pulses = 0; dut_peak = 0;
    repeat (3) cycle(1'b1, 8'h07);
    repeat (120) cycle(1'b0, 8'h00);
    check("b2b_peak", dut_peak, 2);
    check("b2b_pulses", dut_pulses, 3);

    // Saturation with the bell reporting busy, then clear
    bell_mode = 2;
    repeat (20) cycle(1'b1, 8'h07);
    cycle(1'b0, 8'h00);
    check("sat_pending", bif.pending_o, 15);
    check("sat_overflow", bif.overflow_o, 1);
    drv_clr = 1'b1;
    cycle(1'b0, 8'h00);
    drv_clr = 1'b0;
    cycle(1'b0, 8'h00);
    check("clr_overflow", bif.overflow_o, 0);
    check("clr_pending", bif.pending_o, 15);
    drv_en = 1'b0;
    repeat (2) cycle(1'b0, 8'h00);
    check("drain_pending", bif.pending_o, 0);
    drv_en = 1'b1; bell_mode = 0;
    repeat (3) cycle(1'b0, 8'h00);

    // Bell never goes busy: every attempt times out and is consumed
    bell_mode = 1; dut_pulses = 0;
    repeat (3) cycle(1'b1, 8'h07);
    repeat (100) cycle(1'b0, 8'h00);
    check("timeout_pulses", dut_pulses, 3);
    check("timeout_pending", bif.pending_o, 0);
    bell_mode = 0;

    // Disable while a bell is playing with requests queued
    repeat (6) cycle(1'b1, 8'h07);
    n = 0;
    while (m_phase != P_WD && n < 50) begin cycle(1'b0, 8'h00); n++; end
    if (n >= 50) timeout_fail("wait_done_phase");
    drv_en = 1'b0; dut_pulses = 0;
    repeat (2) cycle(1'b0, 8'h00);
    check("dis_pending", bif.pending_o, 0);
    repeat (60) cycle(1'b0, 8'h00);
    check("dis_no_trigger", dut_pulses, 0);
    check("dis_idle", bif.busy_o, 0);
    drv_en = 1'b1;

    // Random traffic in blocks with varying bell behaviour
    for (int blk = 0; blk < 8; blk++) begin
      bell_mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      for (int i = 0; i < 200; i++) begin
        logic [7:0] ch;
        drv_en  = ($urandom_range(0, 19) != 0);
        drv_clr = ($urandom_range(0, 15) == 0);
        ch = ($urandom_range(0, 1) == 1) ? {1'($urandom_range(0, 1)), 7'h07} : 8'($urandom_range(0, 255));
        cycle(($urandom_range(0, 2) == 0), ch);
      end
    end
    bell_mode = 0; drv_clr = 1'b0; drv_en = 1'b0;
    repeat (2) cycle(1'b0, 8'h00);
    n = 0;
    while (m_phase != P_IDLE && n < 300) begin cycle(1'b0, 8'h00); n++; end
    if (n >= 300) timeout_fail("wait_idle");
    drv_en = 1'b1;

    // Asynchronous reset in the middle of a trigger pulse
    cycle(1'b1, 8'h07);
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    check("pre_rst_trigger", bif.bell_trigger_o, 1);
    @(posedge clk);
    #3;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_trigger", bif.bell_trigger_o, 0);
    check("arst_busy", bif.busy_o, 0);
    check("arst_pending", bif.pending_o, 0);
    check("arst_overflow", bif.overflow_o, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    mon_prev_trig = 1'b0;
    chk_en = 1'b1;
    dut_pulses = 0;
    repeat (5) cycle(1'b0, 8'h00);
    check("post_rst_no_bell", dut_pulses, 0);
    cycle(1'b1, 8'h87);
    repeat (40) cycle(1'b0, 8'h00);
    check("post_rst_pulse", dut_pulses, 1);
    @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
